// File: rtl/operand_feeder_if.sv
// Handshake and issue bus between an operand producer, the operand feeder
// and the 2-bit fast-path adder it drives.
interface operand_feeder_if #(
    parameter int W = 2
);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic [W-1:0] op1;
    logic [W-1:0] op2;
    logic         op_valid;

    // Producer side: offers pairs and observes the issued operands.
    modport master (
        output in_valid,
        output in_a,
        output in_b,
        input  in_ready,
        input  op1,
        input  op2,
        input  op_valid
    );

    // Feeder side: accepts pairs and drives the adder operands.
    modport slave (
        input  in_valid,
        input  in_a,
        input  in_b,
        output in_ready,
        output op1,
        output op2,
        output op_valid
    );
endinterface

// File: rtl/operand_feeder.sv
// Operand feeder for the 2-bit fast-path adder: buffers operand pairs in a
// small circular FIFO and issues one pair per cycle on registered op1/op2.
// Cycles with nothing to issue present an all-zero bubble so the adder takes
// its zero fast path. An IDLE/RUN/DRAIN machine gates issuing via enable/flush.
module operand_feeder #(
    parameter int W     = 2,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       enable,
    input  logic                       flush,
    operand_feeder_if.slave            bus,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       busy
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    localparam logic [CW-1:0] FULL  = CW'(DEPTH);
    localparam logic [CW-1:0] ONE   = CW'(1);
    localparam logic [PW-1:0] PSTEP = PW'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t         state;
    logic [2*W-1:0] mem [DEPTH];
    logic [PW-1:0]  rp;
    logic [PW-1:0]  wp;
    logic [2*W-1:0] head;
    logic           push;
    logic           pop;

    // Ready depends only on registered state, so a pop in the same cycle
    // never lets a push into a full buffer.
    assign bus.in_ready = (count < FULL) && (state != DRAIN);
    assign push         = bus.in_valid && bus.in_ready;
    assign pop          = (count != '0) && (state != IDLE);
    assign busy         = (state != IDLE);
    assign head         = mem[rp];

    // Storage write; a push offered while reset is asserted is dropped.
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            mem[wp] <= {bus.in_a, bus.in_b};
        end
    end

    // Pointers, occupancy, issue registers and the enable/flush state machine.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            rp           <= '0;
            wp           <= '0;
            count        <= '0;
            bus.op1      <= '0;
            bus.op2      <= '0;
            bus.op_valid <= 1'b0;
        end else begin
            if (push) begin
                wp <= wp + PSTEP;
            end
            if (pop) begin
                rp <= rp + PSTEP;
            end

            case ({push, pop})
                2'b10:   count <= count + ONE;
                2'b01:   count <= count - ONE;
                default: count <= count;
            endcase

            if (pop) begin
                bus.op1      <= head[2*W-1:W];
                bus.op2      <= head[W-1:0];
                bus.op_valid <= 1'b1;
            end else begin
                bus.op1      <= '0;
                bus.op2      <= '0;
                bus.op_valid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (flush && (count != '0)) begin
                        state <= DRAIN;
                    end else if (enable) begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (flush) begin
                        state <= DRAIN;
                    end else if (!enable && (count == '0)) begin
                        state <= IDLE;
                    end
                end
                DRAIN: begin
                    if ((count == ONE && pop) || (count == '0)) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule
